// File: rtl/ring_pkg.sv
// Shared ring-counter definitions: FSM state encoding and one-hot helpers.
// Functions work on a MAX_W-wide container; callers zero-extend and pass their ring width.
package ring_pkg;

    localparam int unsigned MAX_W = 64;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_LOCKED = 2'd1;
    localparam logic [1:0] ST_ERROR  = 2'd2;

    typedef enum logic [1:0] {
        SEARCH = ST_SEARCH,
        LOCKED = ST_LOCKED,
        ERROR  = ST_ERROR
    } state_t;

    // Single-position left rotate within the low w bits; the one step direction for the ring.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] vec, input int unsigned w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int unsigned i = 1; i < MAX_W; i++) begin
            if (i < w) r[i] = vec[i-1];
        end
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i + 1 == w) r[0] = vec[i];
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [MAX_W-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_W'(1))) == '0);
    endfunction

    function automatic int unsigned onehot2bin(input logic [MAX_W-1:0] vec);
        int unsigned b;
        b = 0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (vec[i]) b = b | i;
        end
        return b;
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot decoder: binary index of the set bit plus a one-hot valid flag.
module onehot_to_bin
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0]         vec,
    output logic [$clog2(WIDTH)-1:0] index,
    output logic                     valid
);

    assign valid = is_onehot(MAX_W'(vec));
    assign index = $clog2(WIDTH)'(onehot2bin(MAX_W'(vec)));

endmodule

// File: rtl/ring_decoder.sv
// Ring-counter monitor: decodes the one-hot position, tracks lock on legal left
// rotations, flags sequence errors and counts completed laps while locked.
module ring_decoder
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned LOCK_N = 2,
    parameter int unsigned LAP_W  = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         q_in,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] idx,
    output logic                     onehot_ok,
    output logic                     locked,
    output logic                     err_pulse,
    output logic                     err_sticky,
    output logic [LAP_W-1:0]         lap_cnt,
    output logic                     lap_pulse
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned SW = $clog2(LOCK_N + 1);

    state_t           state;
    logic [WIDTH-1:0] expected;
    logic [SW-1:0]    step_cnt;
    logic [IW-1:0]    dec_idx;
    logic             dec_valid;
    logic [WIDTH-1:0] next_exp;
    logic             match;

    onehot_to_bin #(.WIDTH(WIDTH)) u_dec (
        .vec   (q_in),
        .index (dec_idx),
        .valid (dec_valid)
    );

    assign next_exp = WIDTH'(rotl(MAX_W'(q_in), WIDTH));
    assign match    = (q_in == expected);
    assign locked   = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= SEARCH;
            expected   <= '0;
            step_cnt   <= '0;
            idx        <= '0;
            onehot_ok  <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            lap_cnt    <= '0;
            lap_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            lap_pulse <= 1'b0;
            if (err_clr) err_sticky <= 1'b0;
            if (en) begin
                onehot_ok <= dec_valid;
                if (dec_valid) idx <= dec_idx;
                case (state)
                    SEARCH: begin
                        if (!dec_valid) begin
                            step_cnt <= '0;
                        end else begin
                            expected <= next_exp;
                            if (!match) begin
                                step_cnt <= '0;
                            end else if (step_cnt == SW'(LOCK_N - 1)) begin
                                state    <= LOCKED;
                                step_cnt <= '0;
                            end else begin
                                step_cnt <= step_cnt + SW'(1);
                            end
                        end
                    end
                    LOCKED: begin
                        // expected is always one-hot here, so a match implies a valid sample
                        if (match) begin
                            expected <= next_exp;
                            if (q_in[0]) begin
                                lap_cnt   <= lap_cnt + LAP_W'(1);
                                lap_pulse <= 1'b1;
                            end
                        end else begin
                            state      <= ERROR;
                            err_pulse  <= 1'b1;
                            err_sticky <= 1'b1;
                        end
                    end
                    default: begin
                        if (dec_valid) begin
                            state    <= SEARCH;
                            expected <= next_exp;
                            step_cnt <= '0;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_decoder.sv
// Scoreboard bench for ring_decoder (WIDTH=4, LOCK_N=2, LAP_W=2).
module tb_ring_decoder;

    localparam int unsigned LOCK_N = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       err_clr = 1'b0;
    logic [3:0] q_in = 4'b0;
    logic [1:0] idx;
    logic       onehot_ok, locked, err_pulse, err_sticky, lap_pulse;
    logic [1:0] lap_cnt;
    logic [8:0] obs;

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    int m_state, m_step, m_pos, m_idx, m_lap;
    bit m_pv, m_ok, m_ep, m_st, m_lp;

    ring_decoder #(.WIDTH(4), .LOCK_N(LOCK_N), .LAP_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .q_in       (q_in),
        .err_clr    (err_clr),
        .idx        (idx),
        .onehot_ok  (onehot_ok),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .lap_cnt    (lap_cnt),
        .lap_pulse  (lap_pulse)
    );

    always #5 clk = ~clk;

    assign obs = {idx, onehot_ok, locked, err_pulse, err_sticky, lap_cnt, lap_pulse};

    // Reference model tracks the last valid position; legal = next position around the ring.
    task automatic model_push(input logic r, input logic e, input logic c, input logic [3:0] q);
        bit oh;
        bit legal;
        int pos;
        oh  = ($countones(q) == 1);
        pos = 0;
        for (int i = 0; i < 4; i++) if (q[i]) pos = i;
        if (r) begin
            m_state = 0; m_step = 0; m_pos = 0; m_idx = 0; m_lap = 0;
            m_pv = 0; m_ok = 0; m_ep = 0; m_st = 0; m_lp = 0;
        end else begin
            m_ep = 0;
            m_lp = 0;
            if (c) m_st = 0;
            if (e) begin
                m_ok = oh;
                if (oh) m_idx = pos;
                legal = oh && m_pv && (pos == (m_pos + 1) % 4);
                case (m_state)
                    0: begin
                        if (oh) begin
                            if (legal) begin
                                m_step++;
                                if (m_step == LOCK_N) begin m_state = 1; m_step = 0; end
                            end else m_step = 0;
                            m_pos = pos; m_pv = 1;
                        end else m_step = 0;
                    end
                    1: begin
                        if (legal) begin
                            m_pos = pos;
                            if (pos == 0) begin m_lap = (m_lap + 1) % 4; m_lp = 1; end
                        end else begin
                            m_state = 2; m_ep = 1; m_st = 1;
                        end
                    end
                    default: begin
                        if (oh) begin m_state = 0; m_pos = pos; m_pv = 1; m_step = 0; end
                    end
                endcase
            end
        end
        exp_q.push_back({2'(m_idx), m_ok, (m_state == 1), m_ep, m_st, 2'(m_lap), m_lp});
    endtask

    task automatic cyc(input logic r, input logic e, input logic c, input logic [3:0] q);
        @(negedge clk);
        reset = r; en = e; err_clr = c; q_in = q;
        model_push(r, e, c, q);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] want;
        for (int i = 0; i < 2; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 4'b0101);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL reset[%0d]: got %b want %b", i, obs, want); end
        end
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL reset_zero: got %b want %b", obs, 9'b0); end
    endtask

    task automatic test_acquire();
        logic [3:0] seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [8:0] want;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 1'b0, seq[i]);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL acquire[%0d]: got %b want %b", i, obs, want); end
            if (i == 2) begin
                checks++;
                if (locked !== 1'b1) begin errors++; $display("FAIL acquire_lock: got %b want 1", locked); end
            end
        end
        checks++;
        if ({lap_cnt, err_sticky, idx} !== {2'd1, 1'b0, 2'd0}) begin
            errors++; $display("FAIL acquire_end: got lap=%0d sticky=%b idx=%0d want 1 0 0", lap_cnt, err_sticky, idx);
        end
    endtask

    task automatic test_seq_error();
        logic [3:0] seq [6] = '{4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [8:0] want;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, seq[i]);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL seq_error[%0d]: got %b want %b", i, obs, want); end
            if (i == 2) begin
                checks++;
                if ({err_pulse, err_sticky, locked} !== 3'b110) begin
                    errors++; $display("FAIL seq_error_flag: got %b want 110", {err_pulse, err_sticky, locked});
                end
            end
        end
        checks++;
        if ({locked, err_sticky, err_pulse} !== 3'b110) begin
            errors++; $display("FAIL seq_error_relock: got %b want 110", {locked, err_sticky, err_pulse});
        end
        cyc(1'b0, 1'b1, 1'b1, 4'b0001);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin errors++; $display("FAIL seq_error_clr: got %b want %b", obs, want); end
        checks++;
        if (err_sticky !== 1'b0) begin errors++; $display("FAIL seq_error_sticky_clr: got %b want 0", err_sticky); end
    endtask

    task automatic test_illegal();
        logic [3:0] seq [6] = '{4'b0010, 4'b0000, 4'b0110, 4'b0001, 4'b0010, 4'b0100};
        logic [8:0] want;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b1, 1'b0, seq[i]);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL illegal[%0d]: got %b want %b", i, obs, want); end
            if (i == 2) begin
                checks++;
                if ({onehot_ok, idx, locked} !== {1'b0, 2'd1, 1'b0}) begin
                    errors++; $display("FAIL illegal_hold: got ok=%b idx=%0d lock=%b want 0 1 0", onehot_ok, idx, locked);
                end
            end
        end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL illegal_relock: got %b want 1", locked); end
    endtask

    task automatic test_enable();
        logic [8:0] want;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 4'($urandom));
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL enable_hold[%0d]: got %b want %b", i, obs, want); end
        end
        checks++;
        if ({locked, idx, err_pulse} !== {1'b1, 2'd2, 1'b0}) begin
            errors++; $display("FAIL enable_state: got lock=%b idx=%0d ep=%b want 1 2 0", locked, idx, err_pulse);
        end
        cyc(1'b0, 1'b1, 1'b0, 4'b1000);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin errors++; $display("FAIL enable_resume: got %b want %b", obs, want); end
    endtask

    task automatic test_lap_wrap();
        logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [8:0] want;
        int start;
        int pulses;
        start  = int'(lap_cnt);
        pulses = 0;
        for (int lap = 0; lap < 5; lap++) begin
            for (int i = 0; i < 4; i++) begin
                cyc(1'b0, 1'b1, 1'b0, seq[i]);
                want = exp_q.pop_front();
                checks++;
                if (obs !== want) begin errors++; $display("FAIL lap_wrap[%0d.%0d]: got %b want %b", lap, i, obs, want); end
                if (lap_pulse === 1'b1) begin
                    pulses++;
                    checks++;
                    if (lap_cnt !== 2'((start + pulses) % 4)) begin
                        errors++; $display("FAIL lap_wrap_cnt: got %0d want %0d", lap_cnt, (start + pulses) % 4);
                    end
                end
            end
        end
        checks++;
        if (pulses != 5) begin errors++; $display("FAIL lap_wrap_pulses: got %0d want 5", pulses); end
    endtask

    task automatic test_races();
        logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        logic [8:0] want;
        cyc(1'b0, 1'b1, 1'b1, 4'b0100);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin errors++; $display("FAIL race_clr: got %b want %b", obs, want); end
        checks++;
        if ({err_sticky, err_pulse} !== 2'b11) begin
            errors++; $display("FAIL race_clr_sticky: got %b want 11", {err_sticky, err_pulse});
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 1'b1, 1'b0, seq[i]);
            want = exp_q.pop_front();
            checks++;
            if (obs !== want) begin errors++; $display("FAIL race_relock[%0d]: got %b want %b", i, obs, want); end
        end
        cyc(1'b1, 1'b1, 1'b0, 4'b0001);
        want = exp_q.pop_front();
        checks++;
        if (obs !== 9'b0) begin errors++; $display("FAIL race_reset: got %b want %b", obs, 9'b0); end
        cyc(1'b0, 1'b1, 1'b0, 4'b0010);
        want = exp_q.pop_front();
        checks++;
        if (obs !== want) begin errors++; $display("FAIL race_after_reset: got %b want %b", obs, want); end
    endtask

    initial begin
        test_reset();
        test_acquire();
        test_seq_error();
        test_illegal();
        test_enable();
        test_lap_wrap();
        test_races();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
